// File: rtl/branch_pred_unit_pkg.sv
// Shared branch-unit types: f3Br funct3 encodings and the 2-bit saturating counter.
// Imported by the comparator and the prediction/resolve top.
package branch_pred_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  function automatic ctr_t ctr_update(input ctr_t cur, input logic taken);
    ctr_t nxt;
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_pred_unit_cmp.sv
// Conditional-branch comparator: purely combinational, no backpressure.
// Reserved funct3 codes report illegal and never taken.
module branch_cmp
  import branch_pred_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  logic eq, lt_s, lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = !lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = !lt_u;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_pred_unit.sv
// Branch resolve + 2-bit BHT predictor; results appear 1 cycle after accept.
// Single output slot: rv_ready drops while the slot is full and not being drained, or on flush.
module branch_pred_unit
  import branch_pred_unit_pkg::*;
#(
  parameter int         XLEN         = 32,
  parameter int         BHT_DEPTH    = 64,
  parameter logic [1:0] COUNTER_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lk_pc,
  output logic            lk_pred_taken,
  input  logic            rv_valid,
  output logic            rv_ready,
  input  logic            rv_branch,
  input  logic [2:0]      rv_funct3,
  input  logic [XLEN-1:0] rv_rs1,
  input  logic [XLEN-1:0] rv_rs2,
  input  logic [XLEN-1:0] rv_pc,
  input  logic [XLEN-1:0] rv_imm,
  input  logic            rv_pred_taken,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic            out_mispredict,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_redirect_pc
);

  localparam int IDXW = $clog2(BHT_DEPTH);

  typedef struct packed {
    logic            taken;
    logic            mispredict;
    logic            illegal;
    logic [XLEN-1:0] redirect_pc;
  } res_t;

  ctr_t            bht [BHT_DEPTH];
  logic [IDXW-1:0] lk_idx, rv_idx;
  logic            cmp_taken, cmp_illegal;
  logic            accept, train, br_taken;
  logic [XLEN-1:0] target, fallthrough;
  res_t            res_d, res_q;
  logic            unused_lk_bits;

  assign lk_idx         = lk_pc[IDXW+1:2];
  assign rv_idx         = rv_pc[IDXW+1:2];
  assign unused_lk_bits = ^{lk_pc[XLEN-1:IDXW+2], lk_pc[1:0]};

  // Lookup reads the registered table only; a same-cycle train is not bypassed.
  assign lk_pred_taken = bht[lk_idx][1];

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3  (rv_funct3),
    .rs1     (rv_rs1),
    .rs2     (rv_rs2),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  assign rv_ready    = !flush && (!out_valid || out_ready);
  assign accept      = rv_valid && rv_ready;
  assign br_taken    = rv_branch && cmp_taken;
  assign train       = accept && rv_branch && !cmp_illegal;
  assign target      = rv_pc + rv_imm;
  assign fallthrough = rv_pc + XLEN'(4);

  always_comb begin
    res_d             = '0;
    res_d.taken       = br_taken;
    res_d.mispredict  = br_taken ^ rv_pred_taken;
    res_d.illegal     = rv_branch && cmp_illegal;
    res_d.redirect_pc = br_taken ? target : fallthrough;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= ctr_t'(COUNTER_INIT);
    end else if (train) begin
      bht[rv_idx] <= ctr_update(bht[rv_idx], br_taken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      res_q     <= res_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_taken       = res_q.taken;
  assign out_mispredict  = res_q.mispredict;
  assign out_illegal     = res_q.illegal;
  assign out_redirect_pc = res_q.redirect_pc;

endmodule

// File: doc/branch_pred_unit.md
# branch_pred_unit

Parametrised branch resolution and prediction unit for the execute stage. It evaluates the six RV32/RV64 conditional-branch comparisons at any XLEN and computes the branch target. It detects misprediction against the fetch-stage guess and trains a direct-mapped table of 2-bit saturating counters that fetch queries for its next prediction. Results leave through a single registered slot with a valid/ready handshake toward the writeback/redirect logic.

## Interface
- XLEN, 32, operand/PC width (32 or 64)
- BHT_DEPTH, 64, counter entries; power of two, ≥ 2
- COUNTER_INIT, 2'b01, reset value of every counter (weakly not-taken)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- lk_pc  in  XLEN  fetch lookup PC
- lk_pred_taken  out  1  combinational: MSB of counter indexed by lk_pc
- rv_valid  in  1  resolve request valid
- rv_ready  out  1  request accepted when rv_valid && rv_ready
- rv_branch  in  1  request is a conditional branch
- rv_funct3  in  3  comparison select, f3Br encoding
- rv_rs1, rv_rs2  in  XLEN  operands
- rv_pc  in  XLEN  branch PC
- rv_imm  in  XLEN  sign-extended B-immediate
- rv_pred_taken  in  1  direction fetch predicted
- flush  in  1  pipeline kill
- out_valid  out  1  result slot full
- out_ready  in  1  consumer takes result when out_valid && out_ready
- out_taken, out_mispredict, out_illegal  out  1  resolved flags
- out_redirect_pc  out  XLEN  correct next PC

## Operation
- Comparisons: EQ 000, NE 001, LT 100 (signed), GE 101 (signed), LTU 110, GEU 111. Codes 010/011: taken=0, illegal=1, no training.
- rv_branch=0: taken=0, illegal=0, no training.
- target = rv_pc + rv_imm; fallthrough = rv_pc + 4; both modulo 2^XLEN (wrap, no flag).
- redirect_pc = taken ? target : fallthrough; mispredict = taken ^ rv_pred_taken.
- Index = pc[log2(BHT_DEPTH)+1 : 2] for both lookup and training.
- Training on accept of a legal branch: taken → counter+1 saturating at 3; not-taken → counter−1 saturating at 0.
- Output slot: rv_ready = !flush && (!out_valid || out_ready). Accept loads slot with computed fields, out_valid=1. Consume without accept → out_valid=0. Consume and accept in the same cycle → slot reloads, out_valid stays 1.
- flush: out_valid=0 next edge. rv_ready is low, so nothing is accepted and no training occurs. Table contents are kept.

## Timing
- Resolve latency: 1 cycle, accept edge → out_* valid.
- Throughput: 1 per cycle while out_ready=1.
- Lookup is combinational on table state. Training becomes visible to lookup the cycle after the accept edge. A same-cycle lookup of the index being trained returns the old value; there is no bypass.
- out_* fields hold stable while out_valid && !out_ready.
- Reset (async assert, sync-safe release): out_valid=0, out_taken=0, out_mispredict=0, out_illegal=0, out_redirect_pc=0, all counters=COUNTER_INIT. Reset mid-transaction discards the slot.

## Structure
- Shared package: f3Br funct3 constants (existing) and a 2-bit counter typedef with SNT/WNT/WT/ST constants.
- Sub-module `branch_cmp`: combinational comparator (XLEN parameter; funct3, rs1, rs2 → taken, illegal). The top holds the table, adders and output slot.

## Test plan
- XLEN=32, rs1=rs2=32'hdeadbeef, EQ, pred=0, pc=32'h100, imm=32'h20 → next cycle out_valid=1, taken=1, mispredict=1, redirect_pc=32'h120.
- LT rs1=32'hfedcba98, rs2=32'h12345678 → taken=1. LTU with same operands → taken=0, redirect_pc=pc+4.
- Train: four taken BEQ at pc=32'h40 from reset. Lookup at 32'h40 reads 0,1,1,1 after edges 0..3, and the counter saturates at 3. Then four not-taken reach 0 and saturate.
- Backpressure: out_ready=0 with two requests. The first is held stable, rv_ready=0, and the second waits. Raising out_ready gives back-to-back results with no bubble.
- funct3=3'b010 → illegal=1, taken=0, counter unchanged. pc=32'hfffffffc, imm=8 → redirect_pc=32'h4 (wrap).
- flush with rv_valid=1 and out_valid=1 → rv_ready=0, out_valid=0 next cycle, counter unchanged. Assert rst_n=0 mid-stream → out_valid immediately 0 and lookup returns COUNTER_INIT MSB.
